// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM slot arbiter: CPU FSM encoding and slot-index helpers.
package vram_pkg;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_PEND = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_e;

    // Wide enough for slot indices 0..PLANES with up to four planes.
    localparam int MAX_PLANES = 4;
    localparam int SLOT_W     = 3;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s,
                                                    input logic [SLOT_W-1:0] last);
        return (s == last) ? '0 : s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/vram_mask_pe.sv
// Lowest-set-bit priority encoder over the plane write mask.
module vram_mask_pe #(
    parameter int PLANES = 3,
    parameter int PW     = 2
) (
    input  logic [PLANES-1:0] mask,
    output logic [PW-1:0]     idx,
    output logic              valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = PLANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = PW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-sliced SRAM arbiter: PLANES video fetch slots plus one CPU slot per frame.
//   state    | meaning
//   CPU_IDLE | no request held; inputs latched when cpu_req rises
//   CPU_PEND | request latched, waiting for / using CPU slots
//   CPU_DONE | access finished; waits for cpu_req to drop
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int PLANES = 3,
    parameter int AW     = 14,
    parameter int PW     = $clog2(PLANES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ce,
    input  logic [AW-1:0]       vid_a,
    output logic [PLANES*8-1:0] vid_q,
    output logic                vid_valid,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_a,
    input  logic [7:0]          cpu_d,
    input  logic [PLANES-1:0]   cpu_mask,
    input  logic [PW-1:0]       cpu_rsel,
    output logic [7:0]          cpu_q,
    output logic                cpu_wait,
    output logic [PW+AW-1:0]    ramA,
    output logic [7:0]          ramDo,
    input  logic [7:0]          ramDi,
    output logic                ramWe,
    output logic                ramOe
);

    localparam logic [SLOT_W-1:0] CPU_SLOT = SLOT_W'(PLANES);
    localparam logic [SLOT_W-1:0] LAST_VID = SLOT_W'(PLANES - 1);

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                run_q, run_d;
    cpu_state_e          state_q, state_d;
    logic [AW-1:0]       a_q, a_d, vid_a_q, vid_a_d, vid_a_sel;
    logic [7:0]          d_q, d_d, cpu_rd_q, cpu_rd_d, ram_do_q, ram_do_d;
    logic                we_q, we_d, vid_valid_q, vid_valid_d;
    logic [PLANES-1:0]   mask_q, mask_d;
    logic [PW-1:0]       rsel_q, rsel_d;
    logic [PLANES*8-1:0] vid_data_q, vid_data_d;
    logic [PW+AW-1:0]    ram_a_q, ram_a_d;
    logic                ram_we_q, ram_we_d, ram_oe_q, ram_oe_d;
    logic                cpu_act_q, cpu_act_d;
    logic [PW-1:0]       pe_idx;
    logic                pe_valid;

    vram_mask_pe #(.PLANES(PLANES), .PW(PW)) u_mask_pe (
        .mask  (mask_q),
        .idx   (pe_idx),
        .valid (pe_valid)
    );

    always_comb begin
        slot_d      = slot_q;
        run_d       = run_q;
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        we_d        = we_q;
        mask_d      = mask_q;
        rsel_d      = rsel_q;
        vid_a_d     = vid_a_q;
        vid_a_sel   = vid_a_q;
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        cpu_rd_d    = cpu_rd_q;
        ram_a_d     = ram_a_q;
        ram_do_d    = ram_do_q;
        ram_we_d    = ram_we_q;
        ram_oe_d    = ram_oe_q;
        cpu_act_d   = cpu_act_q;

        case (state_q)
            CPU_IDLE: if (cpu_req) begin
                state_d = CPU_PEND;
                a_d     = cpu_a;
                d_d     = cpu_d;
                we_d    = cpu_we;
                mask_d  = cpu_mask;
                rsel_d  = cpu_rsel;
            end
            CPU_PEND: if (we_q && mask_q == '0) state_d = CPU_DONE;
            CPU_DONE: if (!cpu_req) state_d = CPU_IDLE;
            default:  state_d = CPU_IDLE;
        endcase

        if (ce) begin
            // The first ce after reset only opens slot 0; nothing has been fetched yet.
            if (!run_q) begin
                run_d = 1'b1;
            end else begin
                for (int p = 0; p < PLANES; p++) begin
                    if (slot_q == SLOT_W'(p)) vid_data_d[8*p +: 8] = ramDi;
                end
                if (slot_q == LAST_VID) vid_valid_d = 1'b1;
                if (slot_q == CPU_SLOT && cpu_act_q) begin
                    if (we_q) begin
                        mask_d = mask_q & ~(PLANES'(1) << pe_idx);
                        if (mask_d == '0) state_d = CPU_DONE;
                    end else begin
                        cpu_rd_d = ramDi;
                        state_d  = CPU_DONE;
                    end
                end
                slot_d = next_slot(slot_q, CPU_SLOT);
            end

            // Set up the bus for the slot that starts on this ce.
            ram_we_d  = 1'b1;
            ram_oe_d  = 1'b0;
            cpu_act_d = 1'b0;
            if (slot_d == CPU_SLOT) begin
                if (state_q == CPU_PEND) begin
                    if (!we_q) begin
                        ram_a_d   = {rsel_q, a_q};
                        cpu_act_d = 1'b1;
                    end else if (pe_valid) begin
                        ram_a_d   = {pe_idx, a_q};
                        ram_do_d  = d_q;
                        ram_we_d  = 1'b0;
                        ram_oe_d  = 1'b1;
                        cpu_act_d = 1'b1;
                    end
                end
            end else begin
                if (slot_d == '0) begin
                    vid_a_d   = vid_a;
                    vid_a_sel = vid_a;
                end
                ram_a_d = {slot_d[PW-1:0], vid_a_sel};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q      <= '0;
            run_q       <= 1'b0;
            state_q     <= CPU_IDLE;
            a_q         <= '0;
            d_q         <= '0;
            we_q        <= 1'b0;
            mask_q      <= '0;
            rsel_q      <= '0;
            vid_a_q     <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_rd_q    <= 8'hFF;
            ram_a_q     <= '0;
            ram_do_q    <= '0;
            ram_we_q    <= 1'b1;
            ram_oe_q    <= 1'b0;
            cpu_act_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            run_q       <= run_d;
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            rsel_q      <= rsel_d;
            vid_a_q     <= vid_a_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            cpu_rd_q    <= cpu_rd_d;
            ram_a_q     <= ram_a_d;
            ram_do_q    <= ram_do_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            cpu_act_q   <= cpu_act_d;
        end
    end

    assign vid_q     = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign cpu_q     = cpu_rd_q;
    assign cpu_wait  = cpu_req && (state_q != CPU_DONE);
    assign ramA      = ram_a_q;
    assign ramDo     = ram_do_q;
    assign ramWe     = ram_we_q;
    assign ramOe     = ram_oe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with an SRAM model and a slot-level reference model.
module tb_vram_arbiter;

    localparam int PLANES = 3;
    localparam int AW     = 14;
    localparam int PW     = 2;

    logic                clock, reset, ce;
    logic [AW-1:0]       vid_a, cpu_a;
    logic [PLANES*8-1:0] vid_q;
    logic                vid_valid, cpu_req, cpu_we, cpu_wait, ramWe, ramOe;
    logic [7:0]          cpu_d, cpu_q, ramDo, ramDi;
    logic [PLANES-1:0]   cpu_mask;
    logic [PW-1:0]       cpu_rsel;
    logic [PW+AW-1:0]    ramA;

    logic [7:0] mem [0:65535];
    assign ramDi = mem[ramA];

    int checks = 0;
    int failures = 0;

    // Slot-level observer state, updated once per falling edge.
    int negcount = 0, mslot = 0, ce_cnt = 0;
    bit started = 1'b0;
    int wr_cnt = 0, we_low_cnt = 0, bad_we = 0;
    int vv_cnt = 0, vv_neg = -100, vv_prev = -100, vv_long = 0, last_cpu_end = 0;
    logic [15:0] last_cpu_a;
    logic [23:0] vv_data;
    logic [15:0] wr_a [0:255];
    logic [7:0]  wr_d [0:255];
    int          wr_end [0:255];

    vram_arbiter #(.PLANES(PLANES), .AW(AW), .PW(PW)) dut (
        .clock(clock), .reset(reset), .ce(ce), .vid_a(vid_a), .vid_q(vid_q),
        .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a),
        .cpu_d(cpu_d), .cpu_mask(cpu_mask), .cpu_rsel(cpu_rsel), .cpu_q(cpu_q),
        .cpu_wait(cpu_wait), .ramA(ramA), .ramDo(ramDo), .ramDi(ramDi),
        .ramWe(ramWe), .ramOe(ramOe)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            ce = (ce_cnt == 3);
            ce_cnt = (ce_cnt + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            negcount++;
            if (ramWe === 1'b0 && !(started && mslot == PLANES)) bad_we++;
            if (ramWe === 1'b0) we_low_cnt++;
            if (vid_valid === 1'b1) begin
                if (vv_neg == negcount - 1) vv_long++;
                vv_prev = vv_neg;
                vv_neg  = negcount;
                vv_cnt++;
                vv_data = vid_q;
            end
            if (reset !== 1'b1) begin
                started = 1'b0;
                mslot   = 0;
            end else if (ce === 1'b1) begin
                if (!started) begin
                    started = 1'b1;
                end else begin
                    if (mslot == PLANES) begin
                        last_cpu_end = negcount;
                        last_cpu_a   = ramA;
                        if (ramWe === 1'b0 && wr_cnt < 256) begin
                            wr_a[wr_cnt]   = ramA;
                            wr_d[wr_cnt]   = ramDo;
                            wr_end[wr_cnt] = negcount;
                            wr_cnt++;
                            mem[ramA] = ramDo;
                        end
                    end
                    mslot = (mslot == PLANES) ? 0 : mslot + 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_vv(output bit ok);
        int c0;
        c0 = vv_cnt;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (vv_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            if (ce === 1'b0) break;
            step();
        end
        reset = 1'b1;
    endtask

    task automatic test_reset();
        step(); step(); step();
        checks++; if (ramWe !== 1'b1) begin failures++; $display("FAIL reset_ramWe got=%b exp=1", ramWe); end
        checks++; if (ramOe !== 1'b0) begin failures++; $display("FAIL reset_ramOe got=%b exp=0", ramOe); end
        checks++; if (ramA !== '0) begin failures++; $display("FAIL reset_ramA got=%h exp=0", ramA); end
        checks++; if (ramDo !== 8'h00) begin failures++; $display("FAIL reset_ramDo got=%h exp=0", ramDo); end
        checks++; if (vid_q !== '0) begin failures++; $display("FAIL reset_vid_q got=%h exp=0", vid_q); end
        checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL reset_vid_valid got=%b exp=0", vid_valid); end
        checks++; if (cpu_q !== 8'hFF) begin failures++; $display("FAIL reset_cpu_q got=%h exp=ff", cpu_q); end
        checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL reset_cpu_wait got=%b exp=0", cpu_wait); end
    endtask

    task automatic test_video(input logic [AW-1:0] a, input logic [23:0] bytes);
        bit ok1, ok2;
        for (int p = 0; p < PLANES; p++) mem[{2'(p), a}] = bytes[8*p +: 8];
        vid_a = a;
        wait_vv(ok1);
        wait_vv(ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL video_timeout got=%b%b exp=11", ok1, ok2); end
        checks++; if (vv_data !== bytes) begin failures++; $display("FAIL video_data got=%h exp=%h", vv_data, bytes); end
        checks++; if (vv_neg - vv_prev != 16) begin failures++; $display("FAIL video_cadence got=%0d exp=16", vv_neg - vv_prev); end
    endtask

    task automatic test_write(input logic [AW-1:0] a, input logic [7:0] d,
                              input logic [PLANES-1:0] mask, input bit align);
        logic [7:0] old [PLANES];
        int base, we0, n, done_neg, k, j, s;
        bit done;
        for (int p = 0; p < PLANES; p++) old[p] = mem[{2'(p), a}];
        base = wr_cnt;
        we0  = we_low_cnt;
        step();
        // Optionally raise the request on the very edge that opens a CPU slot.
        if (align) begin
            for (int i = 0; i < 40; i++) begin
                if (started && ce === 1'b1 && mslot == PLANES) break;
                step();
            end
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = a; cpu_d = d; cpu_mask = mask;
        cpu_rsel = PW'($urandom_range(0, PLANES - 1));
        n = negcount;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            cpu_a = AW'($urandom); cpu_d = 8'($urandom); cpu_mask = PLANES'($urandom);
            cpu_we = 1'($urandom);
            if (cpu_wait === 1'b0) begin done = 1'b1; break; end
        end
        done_neg = negcount;
        cpu_req = 1'b0;
        step();
        k = $countones(mask);
        checks++; if (!done) begin failures++; $display("FAIL write_timeout got=0 exp=1"); end
        checks++; if (wr_cnt - base != k) begin failures++; $display("FAIL write_count got=%0d exp=%0d", wr_cnt - base, k); end
        j = 0;
        for (int p = 0; p < PLANES; p++) begin
            if (mask[p]) begin
                checks++; if (wr_a[base+j] !== {2'(p), a}) begin failures++; $display("FAIL write_addr got=%h exp=%h", wr_a[base+j], {2'(p), a}); end
                checks++; if (wr_d[base+j] !== d) begin failures++; $display("FAIL write_data got=%h exp=%h", wr_d[base+j], d); end
                if (j > 0) begin
                    checks++; if (wr_end[base+j] - wr_end[base+j-1] != 16) begin failures++; $display("FAIL write_consecutive got=%0d exp=16", wr_end[base+j] - wr_end[base+j-1]); end
                end
                j++;
            end else begin
                checks++; if (mem[{2'(p), a}] !== old[p]) begin failures++; $display("FAIL write_unmasked got=%h exp=%h", mem[{2'(p), a}], old[p]); end
            end
        end
        s = wr_end[base] - 4;
        checks++; if (!(s > n && s <= n + 16)) begin failures++; $display("FAIL write_first_slot got=%0d exp=%0d..%0d", s, n + 1, n + 16); end
        checks++; if (done_neg != wr_end[base+k-1] + 1) begin failures++; $display("FAIL write_wait_fall got=%0d exp=%0d", done_neg, wr_end[base+k-1] + 1); end
        checks++; if (we_low_cnt - we0 != 4 * k) begin failures++; $display("FAIL write_we_width got=%0d exp=%0d", we_low_cnt - we0, 4 * k); end
    endtask

    task automatic issue_read(input logic [PW-1:0] rsel, input logic [AW-1:0] a,
                              output bit done, output int n, output int done_neg);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = a; cpu_rsel = rsel;
        n = negcount;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            cpu_a = AW'($urandom); cpu_d = 8'($urandom); cpu_mask = PLANES'($urandom);
            cpu_rsel = PW'($urandom); cpu_we = 1'($urandom);
            if (cpu_wait === 1'b0) begin done = 1'b1; break; end
        end
        done_neg = negcount;
    endtask

    task automatic test_read(input logic [PW-1:0] rsel, input logic [AW-1:0] a, input logic [7:0] val);
        bit done, ok1, ok2;
        int n, done_neg, we0, lce;
        logic [15:0] lca;
        mem[{rsel, a}] = val;
        we0 = we_low_cnt;
        issue_read(rsel, a, done, n, done_neg);
        lce = last_cpu_end;
        lca = last_cpu_a;
        cpu_req = 1'b0;
        step();
        checks++; if (!done) begin failures++; $display("FAIL read_timeout got=0 exp=1"); end
        checks++; if (cpu_q !== val) begin failures++; $display("FAIL read_data got=%h exp=%h", cpu_q, val); end
        checks++; if (lca !== {rsel, a}) begin failures++; $display("FAIL read_addr got=%h exp=%h", lca, {rsel, a}); end
        checks++; if (done_neg != lce + 1) begin failures++; $display("FAIL read_wait_fall got=%0d exp=%0d", done_neg, lce + 1); end
        checks++; if (!(lce - 4 > n && lce - 4 <= n + 16)) begin failures++; $display("FAIL read_slot got=%0d exp=%0d..%0d", lce - 4, n + 1, n + 16); end
        checks++; if (we_low_cnt != we0) begin failures++; $display("FAIL read_no_write got=%0d exp=%0d", we_low_cnt - we0, 0); end
        wait_vv(ok1);
        wait_vv(ok2);
        checks++; if (!(ok1 && ok2) || vv_neg - vv_prev != 16) begin failures++; $display("FAIL read_cadence got=%0d exp=16", vv_neg - vv_prev); end
    endtask

    task automatic test_mask0();
        int we0, wr0;
        we0 = we_low_cnt;
        wr0 = wr_cnt;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_mask = '0; cpu_a = AW'($urandom); cpu_d = 8'($urandom);
        step();
        checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL mask0_wait_1clk got=%b exp=1", cpu_wait); end
        step();
        checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL mask0_wait_2clk got=%b exp=0", cpu_wait); end
        repeat (40) step();
        cpu_req = 1'b0;
        step();
        checks++; if (we_low_cnt != we0 || wr_cnt != wr0) begin failures++; $display("FAIL mask0_no_write got=%0d exp=0", we_low_cnt - we0); end
    endtask

    task automatic test_hold_after_done();
        bit done;
        int n, done_neg, we0, highs;
        logic [AW-1:0] a;
        logic [7:0] val;
        a = AW'($urandom);
        val = 8'($urandom);
        mem[{2'd2, a}] = val;
        issue_read(2'd2, a, done, n, done_neg);
        we0 = we_low_cnt;
        highs = 0;
        cpu_we = 1'b1; cpu_mask = 3'b111;
        for (int i = 0; i < 48; i++) begin
            step();
            if (cpu_wait !== 1'b0) highs++;
        end
        checks++; if (!done || highs != 0) begin failures++; $display("FAIL hold_no_second got=%0d exp=0", highs); end
        checks++; if (cpu_q !== val) begin failures++; $display("FAIL hold_cpu_q got=%h exp=%h", cpu_q, val); end
        checks++; if (we_low_cnt != we0) begin failures++; $display("FAIL hold_no_write got=%0d exp=0", we_low_cnt - we0); end
        cpu_req = 1'b0;
        step();
        test_write(AW'($urandom), 8'($urandom), 3'b010, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        int base, we0;
        bit seen;
        base = wr_cnt;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_mask = 3'b111; cpu_a = AW'($urandom); cpu_d = 8'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ramWe === 1'b0) begin seen = 1'b1; break; end
        end
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        we0 = we_low_cnt;
        checks++; if (!seen) begin failures++; $display("FAIL rstwr_start got=0 exp=1"); end
        checks++; if (ramWe !== 1'b1) begin failures++; $display("FAIL rstwr_ramWe got=%b exp=1", ramWe); end
        checks++; if (ramOe !== 1'b0) begin failures++; $display("FAIL rstwr_ramOe got=%b exp=0", ramOe); end
        checks++; if (cpu_q !== 8'hFF) begin failures++; $display("FAIL rstwr_cpu_q got=%h exp=ff", cpu_q); end
        repeat (3) step();
        release_reset();
        repeat (64) step();
        checks++; if (wr_cnt != base || we_low_cnt != we0) begin failures++; $display("FAIL rstwr_resumed got=%0d exp=0", wr_cnt - base); end
    endtask

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0; cpu_mask = '0; cpu_rsel = '0;
        vid_a = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        test_reset();
        release_reset();
        test_video(14'h0123, 24'h332211);
        for (int i = 0; i < 3; i++) test_video(AW'($urandom), 24'($urandom));
        test_write(14'h0040, 8'hA5, 3'b101, 1'b0);
        test_read(2'd1, 14'h0040, 8'h5A);
        for (int i = 0; i < 4; i++)
            test_write(AW'($urandom), 8'($urandom), PLANES'($urandom_range(1, 7)), i[0]);
        for (int i = 0; i < 3; i++)
            test_read(PW'($urandom_range(0, PLANES - 1)), AW'($urandom), 8'($urandom));
        test_mask0();
        test_hold_after_done();
        test_reset_mid_write();
        test_video(AW'($urandom), 24'($urandom));

        checks++; if (vv_long != 0) begin failures++; $display("FAIL vid_valid_width got=%0d exp=0", vv_long); end
        checks++; if (bad_we != 0) begin failures++; $display("FAIL we_outside_cpu_slot got=%0d exp=0", bad_we); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
